extend_pipe_unit: RTL and testbench

//  Parametrised, registered operand extender for the datapath. Replaces fixed

---
 rtl/extend_pipe_unit_if.sv | 34 +++
 rtl/extend_pipe_unit.sv | 157 +++++++++++++++
 tb/tb_extend_pipe_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/extend_pipe_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : extend_pipe_unit_if
//  Description : Valid/ready handshake bundle for the operand extender.
//                Carries the decode-side input (data, mode) and the
//                ALU-side output (extended word).
//                master modport : producer/consumer side (drives inputs,
//                                 drives out_ready)
//                slave modport  : the extender itself
//  Revision    : 1.0  initial release
// ============================================================================
interface extend_pipe_unit_if #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/extend_pipe_unit.sv
`default_nettype none
// ============================================================================
//  Module      : extend_pipe_unit
//  Description : Registered operand extender (zero / sign / upper / branch
//                offset) with valid/ready handshake on both sides and a
//                2-entry (output register + skid register) buffer, giving
//                full throughput under back-pressure. Latency 1 cycle.
//  Ports       : clk        rising-edge clock
//                reset      asynchronous reset, active-high
//                bus        extend_pipe_unit_if.slave
//                           in_valid/in_ready/in_data/in_mode,
//                           out_valid/out_ready/out_data
//                ext_count  completed output transfers (EXTEND_CNT_EN only)
//  Config      : define EXTEND_CNT_EN to add the ext_count transfer counter
//  Revision    : 1.0  initial release
// ============================================================================
module extend_pipe_unit #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
`ifdef EXTEND_CNT_EN
  output logic [CNT_W-1:0]    ext_count,
`endif
  extend_pipe_unit_if.slave   bus
);

  generate
    if (IN_W < 2 || IN_W >= OUT_W || CNT_W < 1) begin : g_bad_params
      $error("extend_pipe_unit: illegal parameters (need 2 <= IN_W < OUT_W, CNT_W >= 1)");
    end
  endgenerate

  localparam int C_PAD_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,   // output register invalid
    ST_ONE   = 2'd1,   // output register valid, skid empty
    ST_FULL  = 2'd2    // output and skid registers valid
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_oreg;
  logic [OUT_W-1:0] r_skid;

  logic             w_accept;
  logic             w_drain;
  logic             w_load_new;
  logic             w_load_skid;
  logic             w_skid_to_oreg;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_ext;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_drain  = r_out_valid & bus.out_ready;

  // Extension arithmetic
  assign w_sext = {{C_PAD_W{bus.in_data[IN_W-1]}}, bus.in_data};

  always_comb begin
    w_ext = '0;
    case (bus.in_mode)
      2'b00:   w_ext = {{C_PAD_W{1'b0}}, bus.in_data};
      2'b01:   w_ext = w_sext;
      2'b10:   w_ext = {bus.in_data, {C_PAD_W{1'b0}}};
      default: w_ext = w_sext << 2;  // top two bits fall off
    endcase
  end

  // Next-state and load controls
  always_comb begin
    w_state_nxt    = r_state;
    w_load_new     = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_oreg = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_load_new  = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_drain) begin
          w_load_new  = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_drain) begin
          w_state_nxt    = ST_ONE;
          w_skid_to_oreg = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // State register; handshake flags are registered copies of the next-state
  // decode so in_ready has no combinational path from out_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_oreg <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_new) begin
        r_oreg <= w_ext;
      end else if (w_skid_to_oreg) begin
        r_oreg <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_ext;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_oreg;

`ifdef EXTEND_CNT_EN
  logic [CNT_W-1:0] r_ext_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ext_count <= '0;
    end else if (w_drain) begin
      r_ext_count <= r_ext_count + CNT_W'(1);
    end
  end

  assign ext_count = r_ext_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_extend_pipe_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_extend_pipe_unit
//  Description : Directed self-checking bench for extend_pipe_unit. Two
//                instances: IN_W=5 (shamt) and IN_W=16 (immediate, CNT_W=4).
//                Honours EXTEND_CNT_EN for the transfer counter test.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_extend_pipe_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  extend_pipe_unit_if #(.IN_W(5),  .OUT_W(32)) bus5  ();
  extend_pipe_unit_if #(.IN_W(16), .OUT_W(32)) bus16 ();

`ifdef EXTEND_CNT_EN
  logic [15:0] cnt5;
  logic [3:0]  cnt16;
`endif

  extend_pipe_unit #(.IN_W(5), .OUT_W(32), .CNT_W(16)) u_dut5 (
    .clk       (clk),
    .reset     (reset),
`ifdef EXTEND_CNT_EN
    .ext_count (cnt5),
`endif
    .bus       (bus5.slave)
  );

  extend_pipe_unit #(.IN_W(16), .OUT_W(32), .CNT_W(4)) u_dut16 (
    .clk       (clk),
    .reset     (reset),
`ifdef EXTEND_CNT_EN
    .ext_count (cnt16),
`endif
    .bus       (bus16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference extension for the 16-bit instance, via signed arithmetic.
  function automatic logic [31:0] model16(input logic [1:0] m, input logic [15:0] d);
    logic signed [31:0] s;
    s = 32'(signed'(d));
    case (m)
      2'b00:   return {16'h0000, d};
      2'b01:   return s;
      2'b10:   return {d, 16'h0000};
      default: return s * 4;
    endcase
  endfunction

  // IN_W=5 vectors: mode, data, expected
  logic [1:0]  t1_mode [5] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
  logic [4:0]  t1_data [5] = '{5'h1F, 5'h0F, 5'h10, 5'h1F, 5'h11};
  logic [31:0] t1_exp  [5] = '{32'h0000_001F, 32'h0000_000F, 32'hFFFF_FFF0,
                               32'hF800_0000, 32'hFFFF_FFC4};

  // IN_W=16 vectors for 16'h8004
  logic [1:0]  t2_mode [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [31:0] t2_exp  [4] = '{32'h0000_8004, 32'hFFFF_8004, 32'h8004_0000, 32'hFFFE_0010};

  initial begin
    logic [15:0] d;
    logic [1:0]  m;
    logic [31:0] e;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus5.in_valid  = 1'b0; bus5.in_data  = '0; bus5.in_mode  = '0; bus5.out_ready  = 1'b0;
    bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.in_mode = '0; bus16.out_ready = 1'b0;

    #12;
    check_val("rst_out_valid", 64'(bus16.out_valid), 64'd0);
    check_val("rst_in_ready",  64'(bus16.in_ready),  64'd1);
    check_val("rst_out_data",  64'(bus16.out_data),  64'd0);
    check_val("rst5_in_ready", 64'(bus5.in_ready),   64'd1);
    reset = 1'b0;
    tick();

    // T1: IN_W=5 modes, streaming with out_ready=1
    bus5.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus5.in_valid = 1'b1;
      bus5.in_data  = t1_data[i];
      bus5.in_mode  = t1_mode[i];
      tick();
      check_val($sformatf("t1_data%0d", i), 64'(bus5.out_data), 64'(t1_exp[i]));
      check_val($sformatf("t1_valid%0d", i), 64'(bus5.out_valid), 64'd1);
      check_val($sformatf("t1_rdy%0d", i), 64'(bus5.in_ready), 64'd1);
    end
    bus5.in_valid = 1'b0;
    tick();
    check_val("t1_drained", 64'(bus5.out_valid), 64'd0);

    // T2: IN_W=16 modes on 16'h8004
    bus16.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus16.in_valid = 1'b1;
      bus16.in_data  = 16'h8004;
      bus16.in_mode  = t2_mode[i];
      tick();
      check_val($sformatf("t2_data%0d", i), 64'(bus16.out_data), 64'(t2_exp[i]));
    end
    bus16.in_valid = 1'b0;
    tick();
    check_val("t2_drained", 64'(bus16.out_valid), 64'd0);

    // T3: back-pressure, A B C
    bus16.out_ready = 1'b0;
    bus16.in_mode   = 2'b00;
    bus16.in_valid  = 1'b1;
    bus16.in_data   = 16'h1111;
    tick();
    check_val("t3_rdy_after_a", 64'(bus16.in_ready), 64'd1);
    bus16.in_data = 16'h2222;
    tick();
    check_val("t3_rdy_full", 64'(bus16.in_ready), 64'd0);
    bus16.in_data = 16'h3333;
    check_val("t3_head_a", 64'(bus16.out_data), 64'h1111);
    tick();
    check_val("t3_hold_rdy", 64'(bus16.in_ready), 64'd0);
    check_val("t3_hold_a", 64'(bus16.out_data), 64'h1111);
    check_val("t3_hold_valid", 64'(bus16.out_valid), 64'd1);
    bus16.out_ready = 1'b1;
    tick();
    check_val("t3_out_b", 64'(bus16.out_data), 64'h2222);
    check_val("t3_rdy_again", 64'(bus16.in_ready), 64'd1);
    tick();
    bus16.in_valid = 1'b0;
    check_val("t3_out_c", 64'(bus16.out_data), 64'h3333);
    check_val("t3_c_valid", 64'(bus16.out_valid), 64'd1);
    tick();
    check_val("t3_no_dup", 64'(bus16.out_valid), 64'd0);

    // T4: 100-cycle random streaming
    for (int i = 0; i < 100; i++) begin
      d = 16'($urandom);
      m = 2'($urandom);
      bus16.in_valid = 1'b1;
      bus16.in_data  = d;
      bus16.in_mode  = m;
      e = model16(m, d);
      check_val($sformatf("t4_rdy%0d", i), 64'(bus16.in_ready), 64'd1);
      tick();
      check_val($sformatf("t4_data%0d", i), 64'(bus16.out_data), 64'(e));
      check_val($sformatf("t4_valid%0d", i), 64'(bus16.out_valid), 64'd1);
    end
    bus16.in_valid = 1'b0;
    tick();

    // T5: async reset while FULL
    bus16.out_ready = 1'b0;
    bus16.in_valid  = 1'b1;
    bus16.in_mode   = 2'b01;
    bus16.in_data   = 16'hAAAA;
    tick();
    bus16.in_data   = 16'hBBBB;
    tick();
    bus16.in_valid  = 1'b0;
    check_val("t5_full", 64'(bus16.in_ready), 64'd0);
    #2 reset = 1'b1;
    #1;
    check_val("t5_rst_valid", 64'(bus16.out_valid), 64'd0);
    check_val("t5_rst_rdy",   64'(bus16.in_ready),  64'd1);
    check_val("t5_rst_data",  64'(bus16.out_data),  64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus16.out_ready = 1'b1;
    bus16.in_valid  = 1'b1;
    bus16.in_mode   = 2'b00;
    bus16.in_data   = 16'h0C0D;
    tick();
    bus16.in_valid  = 1'b0;
    check_val("t5_first", 64'(bus16.out_data), 64'h0000_0C0D);
    check_val("t5_first_v", 64'(bus16.out_valid), 64'd1);
    tick();
    check_val("t5_no_stale", 64'(bus16.out_valid), 64'd0);

`ifdef EXTEND_CNT_EN
    // T6: 4-bit counter wraps after 16 transfers
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check_val("t6_cnt_rst", 64'(cnt16), 64'd0);
    bus16.out_ready = 1'b1;
    bus16.in_valid  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus16.in_data = 16'(i);
      tick();
    end
    bus16.in_valid = 1'b0;
    tick();
    check_val("t6_cnt_wrap", 64'(cnt16), 64'd1);
    @(negedge clk) reset = 1'b1;
    #1;
    check_val("t6_cnt_clr", 64'(cnt16), 64'd0);
    @(negedge clk) reset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
